// File: rtl/branch_target_stack.sv
// branch_target_stack
//   Return-address stack with registered branch-target select, placed between
//   the EX stage and PC update.  Returns take their target from the top of the
//   stack.  Calls and jumps take their target from the immediate.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   flush          synchronous clear of stack, sticky flags and pending output
//   call_en        branch to imm, push ret_addr
//   ret_en         branch to stack top, pop (with call_en: tail call)
//   jmp_en         branch to imm, stack untouched
//   imm            immediate branch target
//   ret_addr       return address pushed on call
//   branch_valid   registered: branch_addr is valid this cycle
//   branch_addr    registered branch target (holds when no request)
//   empty, full    derived from the registered count
//   count          live entries, 0..DEPTH
//   overflow       sticky: push while full (oldest entry overwritten)
//   underflow      sticky: pop requested while empty
//
// DEPTH must be a power of two and at least 2, so that the stack pointer
// wraps naturally modulo DEPTH.
module branch_target_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] ret_addr,
  output logic              branch_valid,
  output logic [ADDR_W-1:0] branch_addr,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  sp_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              branch_valid_r;
  logic [ADDR_W-1:0] branch_addr_r;

  logic [PTR_W-1:0]  top_idx_s;
  logic [ADDR_W-1:0] top_s;
  logic              is_empty_s;
  logic              is_full_s;

  logic [PTR_W-1:0]  sp_nxt_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              overflow_nxt_s;
  logic              underflow_nxt_s;
  logic              valid_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic              wr_en_s;
  logic [PTR_W-1:0]  wr_idx_s;

  // The top entry sits just below the write pointer; the subtraction wraps modulo DEPTH.
  assign top_idx_s  = sp_r - PTR_W'(1);
  assign top_s      = mem_r[top_idx_s];
  assign is_empty_s = (count_r == CNT_W'(0));
  assign is_full_s  = (count_r == CNT_W'(DEPTH));

  // Request decode: next stack pointer, count, flags, branch target and write port.
  always_comb begin
    sp_nxt_s        = sp_r;
    count_nxt_s     = count_r;
    overflow_nxt_s  = overflow_r;
    underflow_nxt_s = underflow_r;
    valid_nxt_s     = 1'b0;
    addr_nxt_s      = branch_addr_r;
    wr_en_s         = 1'b0;
    wr_idx_s        = sp_r;

    if (flush) begin
      sp_nxt_s        = PTR_W'(0);
      count_nxt_s     = CNT_W'(0);
      overflow_nxt_s  = 1'b0;
      underflow_nxt_s = 1'b0;
    end else if (ret_en && !call_en) begin
      valid_nxt_s = 1'b1;
      if (!is_empty_s) begin
        addr_nxt_s  = top_s;
        sp_nxt_s    = top_idx_s;
        count_nxt_s = count_r - CNT_W'(1);
      end else begin
        addr_nxt_s      = imm;
        underflow_nxt_s = 1'b1;
      end
    end else if (ret_en && call_en) begin
      // Tail call: the popped slot is immediately reused for the new return address.
      valid_nxt_s = 1'b1;
      wr_en_s     = 1'b1;
      if (!is_empty_s) begin
        addr_nxt_s = top_s;
        wr_idx_s   = top_idx_s;
      end else begin
        addr_nxt_s      = imm;
        underflow_nxt_s = 1'b1;
        sp_nxt_s        = sp_r + PTR_W'(1);
        count_nxt_s     = CNT_W'(1);
      end
    end else if (call_en) begin
      // When full, sp already points at the oldest entry, so the push overwrites it.
      valid_nxt_s = 1'b1;
      addr_nxt_s  = imm;
      wr_en_s     = 1'b1;
      sp_nxt_s    = sp_r + PTR_W'(1);
      if (is_full_s) begin
        overflow_nxt_s = 1'b1;
      end else begin
        count_nxt_s = count_r + CNT_W'(1);
      end
    end else if (jmp_en) begin
      valid_nxt_s = 1'b1;
      addr_nxt_s  = imm;
    end else begin
      valid_nxt_s = 1'b0;
    end
  end

  // Stack storage: cleared on reset, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (wr_en_s && !flush) begin
      mem_r[wr_idx_s] <= ret_addr;
    end
  end

  // Control state and registered branch outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r           <= PTR_W'(0);
      count_r        <= CNT_W'(0);
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
      branch_valid_r <= 1'b0;
      branch_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      sp_r           <= sp_nxt_s;
      count_r        <= count_nxt_s;
      overflow_r     <= overflow_nxt_s;
      underflow_r    <= underflow_nxt_s;
      branch_valid_r <= valid_nxt_s;
      branch_addr_r  <= addr_nxt_s;
    end
  end

  assign branch_valid = branch_valid_r;
  assign branch_addr  = branch_addr_r;
  assign count        = count_r;
  assign empty        = is_empty_s;
  assign full         = is_full_s;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_branch_target_stack.sv
// Self-checking bench for branch_target_stack.  A queue-based stack model
// predicts every output; a negedge compare process checks the DUT against it
// each cycle, and directed sequences pin the model with literal expectations.
module tb_branch_target_stack;

  localparam int AW = 16;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          call_en;
  logic          ret_en;
  logic          jmp_en;
  logic [AW-1:0] imm;
  logic [AW-1:0] ret_addr;
  logic          branch_valid;
  logic [AW-1:0] branch_addr;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int checks;
  int failures;
  bit cmp_en;

  // Reference model state.
  logic [AW-1:0] q[$];
  bit            m_valid;
  logic [AW-1:0] m_addr;
  bit            m_ov;
  bit            m_un;

  branch_target_stack #(.ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .call_en(call_en),
    .ret_en(ret_en), .jmp_en(jmp_en), .imm(imm), .ret_addr(ret_addr),
    .branch_valid(branch_valid), .branch_addr(branch_addr),
    .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_valid = 1'b0;
    m_addr  = '0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
  endfunction

  // Apply one sampled request to the model, straight from the stack rules.
  function automatic void model_step(input bit c, input bit r, input bit j, input bit f,
                                     input logic [AW-1:0] im, input logic [AW-1:0] ra);
    if (f) begin
      q.delete();
      m_ov    = 1'b0;
      m_un    = 1'b0;
      m_valid = 1'b0;
    end else if (r && !c) begin
      m_valid = 1'b1;
      if (q.size() > 0) begin
        m_addr = q.pop_back();
      end else begin
        m_addr = im;
        m_un   = 1'b1;
      end
    end else if (r && c) begin
      m_valid = 1'b1;
      if (q.size() > 0) begin
        m_addr = q[q.size()-1];
        q[q.size()-1] = ra;
      end else begin
        m_addr = im;
        m_un   = 1'b1;
        q.push_back(ra);
      end
    end else if (c) begin
      m_valid = 1'b1;
      m_addr  = im;
      if (q.size() == D) begin
        void'(q.pop_front());
        m_ov = 1'b1;
      end
      q.push_back(ra);
    end else if (j) begin
      m_valid = 1'b1;
      m_addr  = im;
    end else begin
      m_valid = 1'b0;
    end
  endfunction

  // Drive one request, let it be sampled, advance the model, wait for the checking edge.
  task automatic step(input bit c, input bit r, input bit j, input bit f,
                      input logic [AW-1:0] im, input logic [AW-1:0] ra);
    call_en  = c;
    ret_en   = r;
    jmp_en   = j;
    flush    = f;
    imm      = im;
    ret_addr = ra;
    @(posedge clk);
    model_step(c, r, j, f, im, ra);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("branch_valid", 32'(branch_valid), 32'(m_valid));
      chk("branch_addr",  32'(branch_addr),  32'(m_addr));
      chk("count",        32'(count),        32'(q.size()));
      chk("empty",        32'(empty),        32'(q.size() == 0));
      chk("full",         32'(full),         32'(q.size() == D));
      chk("overflow",     32'(overflow),     32'(m_ov));
      chk("underflow",    32'(underflow),    32'(m_un));
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    cmp_en   = 1'b0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    call_en  = 1'b0;
    ret_en   = 1'b0;
    jmp_en   = 1'b0;
    imm      = '0;
    ret_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Reset then idle, then a plain jump.
    chk("rst_valid", 32'(branch_valid), 32'h0);
    chk("rst_addr",  32'(branch_addr),  32'h0);
    chk("rst_empty", 32'(empty),        32'h1);
    idle();
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    chk("jmp_valid", 32'(branch_valid), 32'h1);
    chk("jmp_addr",  32'(branch_addr),  32'h0040);
    chk("jmp_count", 32'(count),        32'h0);
    idle();
    chk("hold_valid", 32'(branch_valid), 32'h0);
    chk("hold_addr",  32'(branch_addr),  32'h0040);

    // Call/return nesting.
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 16'h0101);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1100, 16'h0202);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1200, 16'h0303);
    chk("nest_count", 32'(count), 32'h3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
    chk("nest_ret1", 32'(branch_addr), 32'h0303);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
    chk("nest_ret2", 32'(branch_addr), 32'h0202);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
    chk("nest_ret3", 32'(branch_addr), 32'h0101);
    chk("nest_empty", 32'(empty), 32'h1);
    chk("nest_flags", 32'({overflow, underflow}), 32'h0);

    // Overflow wrap then drain past empty.
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h2000, 16'(i));
    chk("ovf_full",  32'(full),     32'h1);
    chk("ovf_flag",  32'(overflow), 32'h1);
    chk("ovf_count", 32'(count),    32'h8);
    for (int i = 9; i >= 2; i--) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h3000, 16'h0000);
      chk("ovf_ret", 32'(branch_addr), 32'(i));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h3456, 16'h0000);
    chk("unf_addr", 32'(branch_addr), 32'h3456);
    chk("unf_flag", 32'(underflow),   32'h1);

    // Tail call.
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h0AAA);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h4100, 16'h0BBB);
    chk("tail_addr",  32'(branch_addr), 32'h0AAA);
    chk("tail_count", 32'(count),       32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h4200, 16'h0000);
    chk("tail_ret", 32'(branch_addr), 32'h0BBB);

    // Priority and flush.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h4300, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0500, 16'h0600);
    chk("pri_addr",  32'(branch_addr), 32'h0500);
    chk("pri_count", 32'(count),       32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0510, 16'h0610);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0520, 16'h0000);
    chk("fl_valid", 32'(branch_valid), 32'h0);
    chk("fl_count", 32'(count),        32'h0);
    chk("fl_flags", 32'({overflow, underflow}), 32'h0);

    // Asynchronous reset mid-stream with count=5 and overflow set.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h5000, 16'(16'h50 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h5100, 16'h0000);
    chk("pre_rst_count", 32'(count),    32'h5);
    chk("pre_rst_ovf",   32'(overflow), 32'h1);
    call_en = 1'b1;
    ret_addr = 16'h5555;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", 32'(branch_valid), 32'h0);
    chk("arst_addr",  32'(branch_addr),  32'h0);
    chk("arst_count", 32'(count),        32'h0);
    chk("arst_empty", 32'(empty),        32'h1);
    chk("arst_ovf",   32'(overflow),     32'h0);
    call_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0777, 16'h0000);
    chk("post_rst_unf",  32'(underflow),   32'h1);
    chk("post_rst_addr", 32'(branch_addr), 32'h0777);

    // Randomized traffic: call/ret overlap produces tail calls, rare flushes.
    for (int n = 0; n < 2500; n++) begin
      int rv;
      bit c, r, j, f;
      rv = int'($urandom_range(0, 99));
      c  = (rv < 35);
      r  = (rv >= 25) && (rv < 62);
      j  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 63) == 0);
      step(c, r, j, f, 16'($urandom), 16'($urandom));
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
